// File: rtl/clkgen_pkg.sv
// Shared state encoding and default timing constants for the DCM reset sequencer.
package clkgen_pkg;

  typedef logic [2:0] state_t;

  // Legacy-compatible state encoding
  localparam state_t StDfsRst  = 3'd0;
  localparam state_t StDfsWait = 3'd1;
  localparam state_t StDllRst  = 3'd2;
  localparam state_t StDllWait = 3'd3;
  localparam state_t StStable  = 3'd4;
  localparam state_t StRun     = 3'd5;
  localparam state_t StFail    = 3'd6;

  localparam int unsigned DefRstHold      = 4;
  localparam logic [15:0] DefLockTimeout  = 16'd50000;
  localparam int unsigned DefStableCycles = 1024;
  localparam int unsigned DefMaxRetry     = 7;

  // Saturating increment for the 8-bit lock-loss counter
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  // Capture stage followed by the resolved output stage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/clkgen_rst_seq.sv
// Reset sequencer for a cascaded DFS -> DLL DCM pair: brings up both DCMs in
// order, waits for stable lock, releases the core reset, and recovers from
// lock timeouts and lock loss.
module clkgen_rst_seq
  import clkgen_pkg::*;
#(
  parameter int unsigned RST_HOLD      = DefRstHold,
  parameter logic [15:0] LOCK_TIMEOUT  = DefLockTimeout,
  parameter int unsigned STABLE_CYCLES = DefStableCycles,
  parameter int unsigned MAX_RETRY     = DefMaxRetry
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       restart,
  input  logic       dfs_locked,
  input  logic       dll_locked,
  output logic       dfs_rst,
  output logic       dll_rst,
  output logic       sys_rst,
  output logic       clk_ok,
  output logic       fail,
  output logic [2:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  localparam logic [15:0] HoldLast   = 16'(RST_HOLD - 1);
  localparam logic [15:0] StableLast = 16'(STABLE_CYCLES - 1);
  localparam logic [2:0]  MaxRetry   = 3'(MAX_RETRY);

  logic [1:0]  lock_s;
  logic        dfs_s;
  logic        dll_s;
  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  retry_q, retry_d;
  logic [7:0]  loss_q, loss_d;
  logic        hold_done;
  logic        stable_done;
  logic        timeout;

  sync2 #(
    .WIDTH(2)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    ({dfs_locked, dll_locked}),
    .q    (lock_s)
  );

  assign dfs_s = lock_s[1];
  assign dll_s = lock_s[0];

  assign hold_done   = (timer_q == HoldLast);
  assign stable_done = (timer_q == StableLast);
  assign timeout     = (timer_q == LOCK_TIMEOUT);

  // Sequencer next state; restart overrides any lock drop or timeout
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    if (restart) begin
      state_d = StDfsRst;
      retry_d = '0;
    end else begin
      case (state_q)
        StDfsRst: begin
          if (hold_done) state_d = StDfsWait;
        end
        StDfsWait: begin
          if (dfs_s) begin
            state_d = StDllRst;
          end else if (timeout) begin
            if (retry_q >= MaxRetry) begin
              state_d = StFail;
            end else begin
              retry_d = retry_q + 3'd1;
              state_d = StDfsRst;
            end
          end
        end
        StDllRst: begin
          if (!dfs_s)         state_d = StDfsRst;
          else if (hold_done) state_d = StDllWait;
        end
        StDllWait: begin
          if (!dfs_s) begin
            state_d = StDfsRst;
          end else if (dll_s) begin
            state_d = StStable;
          end else if (timeout) begin
            if (retry_q >= MaxRetry) begin
              state_d = StFail;
            end else begin
              retry_d = retry_q + 3'd1;
              state_d = StDllRst;
            end
          end
        end
        StStable: begin
          if (!dfs_s) begin
            state_d = StDfsRst;
          end else if (!dll_s) begin
            state_d = StDllRst;
          end else if (stable_done) begin
            state_d = StRun;
            retry_d = '0;
          end
        end
        StRun: begin
          // Lock loss in service is counted separately from bring-up retries
          if (!dfs_s || !dll_s) begin
            loss_d  = sat_inc8(loss_q);
            state_d = !dfs_s ? StDfsRst : StDllRst;
          end
        end
        StFail: begin
          state_d = StFail;
        end
        default: begin
          state_d = StDfsRst;
        end
      endcase
    end
  end

  // One shared timer, cleared on every state entry, saturating instead of wrapping
  always_comb begin
    if (restart || (state_d != state_q)) begin
      timer_d = '0;
    end else if (timer_q == 16'hFFFF) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + 16'd1;
    end
  end

  // Sequencer state and counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StDfsRst;
      timer_q <= '0;
      retry_q <= '0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      loss_q  <= loss_d;
    end
  end

  // Registered outputs decoded from the next state so they track state_q exactly
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dfs_rst <= 1'b1;
      dll_rst <= 1'b1;
      sys_rst <= 1'b1;
      clk_ok  <= 1'b0;
      fail    <= 1'b0;
    end else begin
      dfs_rst <= (state_d == StDfsRst) || (state_d == StFail);
      dll_rst <= (state_d == StDfsRst) || (state_d == StDfsWait) ||
                 (state_d == StDllRst) || (state_d == StFail);
      sys_rst <= (state_d != StRun);
      clk_ok  <= (state_d == StRun);
      fail    <= (state_d == StFail);
    end
  end

  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_clkgen_rst_seq.sv
// Scoreboard bench for clkgen_rst_seq: stimulus queues hand-computed expected
// output values tagged with the cycle they must appear; a monitor on the
// falling edge pops and compares them.
module tb_clkgen_rst_seq;

  localparam int SDfs = 0, SDll = 1, SSys = 2, SOk = 3, SFail = 4, SRetry = 5, SLoss = 6;

  logic       clk = 1'b0;
  logic       rstn;
  logic       restart;
  logic       dfs_locked;
  logic       dll_locked;
  logic       dfs_rst;
  logic       dll_rst;
  logic       sys_rst;
  logic       clk_ok;
  logic       fail;
  logic [2:0] retry_cnt;
  logic [7:0] loss_cnt;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int    at;
    int    sel;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  clkgen_rst_seq #(
    .RST_HOLD      (4),
    .LOCK_TIMEOUT  (16'd200),
    .STABLE_CYCLES (1024),
    .MAX_RETRY     (2)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .restart    (restart),
    .dfs_locked (dfs_locked),
    .dll_locked (dll_locked),
    .dfs_rst    (dfs_rst),
    .dll_rst    (dll_rst),
    .sys_rst    (sys_rst),
    .clk_ok     (clk_ok),
    .fail       (fail),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt)
  );

  always #5 clk = ~clk;

  // After posedge n the counter reads n
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int out_val(input int sel);
    case (sel)
      SDfs:    return int'(dfs_rst);
      SDll:    return int'(dll_rst);
      SSys:    return int'(sys_rst);
      SOk:     return int'(clk_ok);
      SFail:   return int'(fail);
      SRetry:  return int'(retry_cnt);
      default: return int'(loss_cnt);
    endcase
  endfunction

  task automatic expect_at(input int at, input int sel, input int val, input string name);
    exp_t e;
    int   idx;
    e.at   = at;
    e.sel  = sel;
    e.val  = val;
    e.name = name;
    idx    = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].at > at) begin
        idx = i;
        break;
      end
    end
    sb.insert(idx, e);
  endtask

  task automatic expect_reset_vals(input int at, input string tag);
    expect_at(at, SDfs, 1, {tag, "_dfs_rst"});
    expect_at(at, SDll, 1, {tag, "_dll_rst"});
    expect_at(at, SSys, 1, {tag, "_sys_rst"});
    expect_at(at, SOk, 0, {tag, "_clk_ok"});
    expect_at(at, SFail, 0, {tag, "_fail"});
    expect_at(at, SRetry, 0, {tag, "_retry"});
    expect_at(at, SLoss, 0, {tag, "_loss"});
  endtask

  // Inputs change 1 ns after posedge n, so they are first sampled at posedge n+1
  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare every expectation due this cycle
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      cur = sb.pop_front();
      checks++;
      if (cur.at != cyc) begin
        errors++;
        $display("FAIL %s: due at cycle %0d, not sampled until %0d", cur.name, cur.at, cyc);
      end else if (out_val(cur.sel) != cur.val) begin
        errors++;
        $display("FAIL %s @cycle %0d: got %0d, expected %0d",
                 cur.name, cyc, out_val(cur.sel), cur.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn       = 1'b0;
    restart    = 1'b0;
    dfs_locked = 1'b0;
    dll_locked = 1'b0;

    // Reset values, then three timeouts into FAIL (dfs never locks)
    expect_reset_vals(2, "in_reset");
    expect_at(6, SDfs, 1, "hold_last_cycle");
    expect_at(7, SDfs, 0, "dfs_wait_1");
    expect_at(7, SDll, 1, "dfs_wait_1_dll");
    expect_at(207, SRetry, 0, "before_timeout_1");
    expect_at(208, SRetry, 1, "timeout_1_retry");
    expect_at(208, SDfs, 1, "timeout_1_dfs_rst");
    expect_at(211, SDfs, 1, "retry_1_hold");
    expect_at(212, SDfs, 0, "dfs_wait_2");
    expect_at(412, SRetry, 1, "before_timeout_2");
    expect_at(413, SRetry, 2, "timeout_2_retry");
    expect_at(417, SDfs, 0, "dfs_wait_3");
    expect_at(617, SFail, 0, "before_fail");
    expect_at(618, SFail, 1, "fail_set");
    expect_at(618, SRetry, 2, "fail_retry");
    expect_at(618, SDfs, 1, "fail_dfs_rst");
    expect_at(618, SDll, 1, "fail_dll_rst");
    expect_at(618, SSys, 1, "fail_sys_rst");
    expect_at(630, SFail, 1, "fail_held");
    wait_cyc(3);
    rstn = 1'b1;

    // Restart out of FAIL
    expect_at(631, SFail, 0, "restart_fail_clr");
    expect_at(631, SRetry, 0, "restart_retry_clr");
    expect_at(631, SDfs, 1, "restart_dfs_rst");
    expect_at(634, SDfs, 1, "restart_hold");
    expect_at(635, SDfs, 0, "restart_dfs_wait");
    wait_cyc(630);
    restart = 1'b1;
    wait_cyc(631);
    restart = 1'b0;

    // Restart coincident with the DFS_WAIT timeout
    expect_at(835, SRetry, 0, "prio_before");
    expect_at(836, SRetry, 0, "prio_retry");
    expect_at(836, SDfs, 1, "prio_dfs_rst");
    expect_at(839, SDfs, 1, "prio_hold");
    expect_at(840, SDfs, 0, "prio_dfs_wait");
    wait_cyc(835);
    restart = 1'b1;
    wait_cyc(836);
    restart = 1'b0;

    // Nominal bring-up: dfs 100 cycles into DFS_WAIT, dll 100 cycles after dll_rst falls
    expect_at(943, SDfs, 0, "nom_dll_rst_dfs");
    expect_at(943, SDll, 1, "nom_dll_rst_dll");
    expect_at(946, SDll, 1, "nom_dll_hold");
    expect_at(947, SDll, 0, "nom_dll_wait");
    expect_at(2073, SSys, 1, "nom_sys_before");
    expect_at(2073, SOk, 0, "nom_ok_before");
    expect_at(2074, SSys, 0, "nom_sys_release");
    expect_at(2074, SOk, 1, "nom_clk_ok");
    expect_at(2074, SRetry, 0, "nom_retry");
    wait_cyc(940);
    dfs_locked = 1'b1;
    wait_cyc(1047);
    dll_locked = 1'b1;

    // One-cycle dll drop in RUN
    expect_at(2102, SSys, 0, "loss_sys_before");
    expect_at(2102, SLoss, 0, "loss_cnt_before");
    expect_at(2103, SSys, 1, "loss_sys_rst");
    expect_at(2103, SLoss, 1, "loss_cnt_1");
    expect_at(2103, SDll, 1, "loss_dll_rst");
    expect_at(2103, SDfs, 0, "loss_dfs_kept");
    expect_at(2103, SOk, 0, "loss_clk_ok");
    expect_at(2103, SRetry, 0, "loss_retry");
    expect_at(2106, SDll, 1, "loss_dll_hold");
    expect_at(2107, SDll, 0, "loss_dll_wait");
    expect_at(3131, SSys, 1, "relock_sys_before");
    expect_at(3132, SSys, 0, "relock_sys_release");
    expect_at(3132, SLoss, 1, "relock_loss");
    wait_cyc(2100);
    dll_locked = 1'b0;
    wait_cyc(2101);
    dll_locked = 1'b1;

    // Restart from RUN keeps loss_cnt; dfs glitch at STABLE count 500
    expect_at(3201, SSys, 1, "rs_sys_rst");
    expect_at(3201, SLoss, 1, "rs_loss_kept");
    expect_at(3201, SDfs, 1, "rs_dfs_rst");
    expect_at(3205, SDfs, 0, "rs_dfs_wait");
    expect_at(3206, SDll, 1, "rs_dll_rst");
    expect_at(3210, SDll, 0, "rs_dll_wait");
    expect_at(3713, SDfs, 0, "glitch_before");
    expect_at(3714, SDfs, 1, "glitch_dfs_rst");
    expect_at(3714, SSys, 1, "glitch_sys_rst");
    expect_at(3717, SDfs, 1, "glitch_hold");
    expect_at(3718, SDfs, 0, "glitch_dfs_wait");
    expect_at(4235, SSys, 1, "glitch_no_early_release");
    expect_at(4747, SSys, 1, "glitch_sys_before");
    expect_at(4748, SSys, 0, "glitch_sys_release");
    expect_at(4748, SLoss, 1, "glitch_loss_unchanged");
    wait_cyc(3200);
    restart = 1'b1;
    wait_cyc(3201);
    restart = 1'b0;
    wait_cyc(3711);
    dfs_locked = 1'b0;
    wait_cyc(3716);
    dfs_locked = 1'b1;

    // Async reset pulse while in DLL_WAIT
    expect_at(4803, SLoss, 2, "dw_loss_2");
    expect_at(4803, SDll, 1, "dw_dll_rst");
    expect_at(4807, SDll, 0, "dw_dll_wait");
    expect_at(4809, SLoss, 2, "dw_loss_before_rst");
    expect_reset_vals(4810, "async_rst");
    expect_at(4813, SDfs, 1, "post_rst_hold");
    expect_at(4814, SDfs, 0, "post_rst_dfs_wait");
    wait_cyc(4800);
    dll_locked = 1'b0;
    wait_cyc(4810);
    #1 rstn = 1'b0;
    #1 rstn = 1'b1;

    wait_cyc(4820);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
